// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
package mult_pkg;

    localparam int WIDTH  = 16;
    localparam int PWIDTH = 32;
    localparam int POSW   = 5;

    // 2'd3 is unused; the next-state logic steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_shift_16bit.sv
// 16-bit logical-right barrel shifter, four binary-weighted mux stages.
module barrel_shift_16bit (
    input  logic [15:0] in,
    input  logic [3:0]  ctrl,
    output logic [15:0] out
);

    logic [15:0] w_s1;
    logic [15:0] w_s2;
    logic [15:0] w_s4;

    assign w_s1 = ctrl[0] ? {1'b0, in[15:1]}     : in;
    assign w_s2 = ctrl[1] ? {2'b0, w_s1[15:2]}   : w_s1;
    assign w_s4 = ctrl[2] ? {4'b0, w_s2[15:4]}   : w_s2;
    assign out  = ctrl[3] ? {8'b0, w_s4[15:8]}   : w_s4;

endmodule

// File: rtl/ctz16.sv
// Trailing-zero priority encoder; output is don't-care for a zero input.
module ctz16 (
    input  logic [15:0] i_val,
    output logic [3:0]  o_tz
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_tz = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_val[i]) o_tz = 4'(i);
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential 16x16 unsigned multiplier: one set multiplier bit per RUN cycle,
// zero runs skipped with the shared right barrel shifter.
//
//   state | meaning
//   IDLE  | waiting for start; operands sampled on accept
//   RUN   | add one shifted partial product per cycle until b_reg is empty
//   DONE  | product valid, done pulse, then back to IDLE
module seq_mult_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PWIDTH-1:0] product
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [PWIDTH-1:0] r_acc;
    logic [POSW-1:0]   r_pos;

    logic [3:0]        w_tz;
    logic [WIDTH-1:0]  w_sh_out;
    logic [POSW-1:0]   w_shamt;
    logic [PWIDTH-1:0] w_addend;

    ctz16 u_ctz (
        .i_val (r_b),
        .o_tz  (w_tz)
    );

    barrel_shift_16bit u_shift (
        .in   (r_b),
        .ctrl (w_tz),
        .out  (w_sh_out)
    );

    // pos+tz never exceeds 15 while bits remain, so 5 bits cannot wrap.
    assign w_shamt  = r_pos + {1'b0, w_tz};
    assign w_addend = PWIDTH'(r_a) << w_shamt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = (r_b == '0) ? DONE : RUN;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture on accept, one partial product per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_pos <= '0;
        end else if (r_state == IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_pos <= '0;
        end else if (r_state == RUN && r_b != '0) begin
            r_acc <= r_acc + w_addend;
            r_b   <= w_sh_out >> 1;
            r_pos <= w_shamt + 5'd1;
        end
    end

    assign product = r_acc;

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequential 16x16 unsigned multiplier controller that shares one 16-bit logical-right barrel shifter. The shifter skips runs of zeros in the multiplier, so each clock processes exactly one set bit. The block sits between the operand source and the product consumer as the multi-cycle, low-area alternative to an array multiplier. Latency depends on the data: it is popcount(b)+2 cycles.

## Interface
- `WIDTH`, 16, operand width. Fixed at 16 because it matches the shifter; any other value is unsupported.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  16  multiplicand; sampled with an accepted `start`.
- `b`  in  16  multiplier; sampled with an accepted `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `product` is valid in this cycle.
- `product`  out  32  unsigned a*b. Holds its value until the next accepted `start`.

## Operation
- Registers:
  - `a_reg[15:0]`, `b_reg[15:0]`
  - `acc[31:0]`, which drives `product`
  - `pos[4:0]`, range 0..16
  - `state`
- IDLE:
  - `start`=1 → load `a_reg`=a, `b_reg`=b, `acc`=0, `pos`=0; go to RUN.
  - `start`=0 → stay in IDLE.
- RUN, when `b_reg`==0: go to DONE; `acc` is unchanged.
- RUN, when `b_reg`!=0:
  - `tz` = count of trailing zeros of `b_reg` (0..15).
  - Shifter: `sh_in`=`b_reg`, `sh_ctrl`=`tz`.
  - `acc` ← `acc` + ({16'b0,`a_reg`} << (`pos`+`tz`)).
  - `b_reg` ← {1'b0, `sh_out`[15:1]}.
  - `pos` ← `pos`+`tz`+1.
- DONE: `done`=1 for one cycle, then unconditionally go to IDLE.
- Width rules:
  - `pos`+`tz` ≤ 15 on every add.
  - `acc` never exceeds 0xFFFE0001, so there is no overflow and no carry-out.
  - `pos` reaches 16 only when `b_reg` becomes 0.
- `start` while `busy`: ignored, and operands are not sampled. `start` held high through DONE is accepted in the following IDLE cycle.
- `a`=0: handled like any other value, with no shortcut; the product is 0.
- `b`=0: goes straight to DONE; the product is 0.
- Reset at any state, including mid-RUN:
  - Next state is IDLE; all registers are cleared.
  - No `done` pulse is produced for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state=IDLE.
- Let `start` be accepted at edge E0. Then:
  - RUN occupies edges E0+1 .. E0+popcount(b)+1.
  - `done` is high in the cycle after edge E0+popcount(b)+1, which is popcount(b)+2 cycles after the start cycle.
  - Minimum latency is 2 cycles (b=0); maximum is 18 cycles (b=0xFFFF).
- `busy` rises in the cycle after the accepted `start`. It falls in the cycle after `done`.
- The earliest back-to-back `start` is the cycle after `done`. Throughput is therefore popcount(b)+3 cycles per operation.
- The shifter and trailing-zero encoder are combinational within one RUN cycle. There is no pipeline register between them and `acc`.

## Structure
- Package `mult_pkg` holds:
  - `WIDTH`=16, `PWIDTH`=32, `POSW`=5
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE)
- Sub-modules:
  - Instantiate the team's existing `barrel_shift_16bit` unmodified (`in`=`b_reg`, `ctrl`=`tz`).
  - One new sub-module, `ctz16`: combinational trailing-zero priority encoder, 16-bit in, 4-bit out. Its output is don't-care when the input is 0.
- The left shift of `a_reg` is a plain variable shift inside `seq_mult_ctrl`. It does not get a second barrel instance.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → `busy`=0, `done`=0, `product`=0, and no operation starts.
- a=0x0003, b=0x0005 → `done` 4 cycles after the start cycle; `product`=0x0000000F.
- a=0x1234, b=0x8000 (tz=15) → `done` at +3; `product`=0x091A0000; `pos` ends at 16.
- a=0xFFFF, b=0xFFFF → 16 add cycles, `done` at +18, `product`=0xFFFE0001.
- b=0x0000, a=0xABCD → `done` at +2, `product`=0. Pulse `start` with new operands while busy → ignored. Issue `start` the cycle after `done` → accepted; the new result is correct.
- Start a=0x00FF, b=0x0F0F, then assert `rst_n`=0 during the third RUN cycle → IDLE on the next edge, `product`=0, no `done` pulse. A rerun yields 0x000EFFF1 at +10.
